pc_isp: RTL

Program-counter and instruction-stack block that closes the fetch loop around the prefetch decoder. It registers the next fetch address, holds the return-address LIFO that CALL/RETURN (`push`/`pop`) operate on, and arbitrates external interrupt requests into the single-cycle `itr` strobe the prefetch stage consumes. It sits between prefetch and the instruction memory address path, one per processor core.

---
 rtl/pc_isp_if.sv | 28 ++
 rtl/pc_isp.sv | 127 ++++++++++++
 2 files changed

// File: rtl/pc_isp_if.sv
// Fetch-loop bundle between prefetch and the PC / instruction-stack block.
// master = prefetch side, slave = pc_isp side.
interface pc_isp_if #(
    parameter int MINSTW = 8
);
    logic [MINSTW-1:0] instr_addr;
    logic              push;
    logic              pop;
    logic              reti;
    logic              itr_req;
    logic [MINSTW-1:0] addr;
    logic [MINSTW-1:0] tos;
    logic              itr;
    logic              in_itr;
    logic              full;
    logic              empty;
    logic              err;

    modport master (
        output instr_addr, push, pop, reti, itr_req,
        input  addr, tos, itr, in_itr, full, empty, err
    );

    modport slave (
        input  instr_addr, push, pop, reti, itr_req,
        output addr, tos, itr, in_itr, full, empty, err
    );
endinterface

// File: rtl/pc_isp.sv
// Program counter, return-address LIFO and single-level interrupt strobe for the prefetch loop.
// Latency: addr/status 1 cycle, tos combinational. No backpressure; overflow/underflow set sticky err.
module pc_isp #(
    parameter int MINSTW = 8,
    parameter int ISPDPT = 16,
    parameter int ISPAW  = 4
) (
    input logic   clk,
    input logic   rst,
    pc_isp_if.slave isp
);

    localparam logic [ISPAW:0] SP_MAX = (ISPAW+1)'(ISPDPT);

    logic [MINSTW-1:0] pc, pc_nxt;
    logic [MINSTW-1:0] stk [ISPDPT];
    logic [ISPAW:0]    sp, sp_nxt;
    logic              itr_q, itr_nxt;
    logic              in_itr_q, in_itr_nxt;
    logic              err_q, err_nxt;
    logic              pop_d;

    logic              stk_we;
    logic [ISPAW-1:0]  stk_wa;
    logic [MINSTW-1:0] stk_wd;

    logic              empty, full, accept;
    logic [ISPAW-1:0]  top_idx, sp_idx;
    logic [MINSTW-1:0] tos, seq_addr;

    assign empty    = (sp == '0);
    assign full     = (sp == SP_MAX);
    assign top_idx  = ISPAW'(sp - 1'b1);
    assign sp_idx   = ISPAW'(sp);
    assign tos      = empty ? '0 : stk[top_idx];
    assign seq_addr = isp.instr_addr + 1'b1;

    // pop_d keeps the return just taken from being interrupted before it lands
    assign accept = isp.itr_req & ~in_itr_q & ~itr_q & ~isp.push & ~isp.pop
                  & ~pop_d & ~full;

    always_comb begin
        pc_nxt     = seq_addr;
        sp_nxt     = sp;
        itr_nxt    = 1'b0;
        in_itr_nxt = in_itr_q;
        err_nxt    = err_q;
        stk_we     = 1'b0;
        stk_wa     = sp_idx;
        stk_wd     = pc;

        if (itr_q) begin
            // Stack the instruction in decode so it re-executes after reti
            stk_we = 1'b1;
            stk_wd = pc - 1'b1;
            sp_nxt = sp + 1'b1;
        end else begin
            if (isp.push && isp.pop) begin
                if (!empty) begin
                    stk_we = 1'b1;
                    stk_wa = top_idx;
                    pc_nxt = tos;
                    if (isp.reti)
                        in_itr_nxt = 1'b0;
                end else begin
                    err_nxt = 1'b1;
                    stk_we  = 1'b1;
                    sp_nxt  = sp + 1'b1;
                end
            end else if (isp.pop) begin
                if (!empty) begin
                    pc_nxt = tos;
                    sp_nxt = sp - 1'b1;
                    if (isp.reti)
                        in_itr_nxt = 1'b0;
                end else begin
                    err_nxt = 1'b1;
                end
            end else if (isp.push) begin
                if (!full) begin
                    stk_we = 1'b1;
                    sp_nxt = sp + 1'b1;
                end else begin
                    err_nxt = 1'b1;
                end
            end

            if (accept) begin
                itr_nxt    = 1'b1;
                in_itr_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc       <= '0;
            sp       <= '0;
            itr_q    <= 1'b0;
            in_itr_q <= 1'b0;
            err_q    <= 1'b0;
            pop_d    <= 1'b0;
        end else begin
            pc       <= pc_nxt;
            sp       <= sp_nxt;
            itr_q    <= itr_nxt;
            in_itr_q <= in_itr_nxt;
            err_q    <= err_nxt;
            pop_d    <= isp.pop;
        end
    end

    // Stack storage is deliberately left uncleared by reset
    always_ff @(posedge clk) begin
        if (stk_we)
            stk[stk_wa] <= stk_wd;
    end

    assign isp.addr   = pc;
    assign isp.tos    = tos;
    assign isp.itr    = itr_q;
    assign isp.in_itr = in_itr_q;
    assign isp.full   = full;
    assign isp.empty  = empty;
    assign isp.err    = err_q;

endmodule
